// File: rtl/counter_4bit.sv
// Generic up/down event counter with synchronous load, terminal-count flag
// and a registered wrap pulse. Width and reset value are set per instance.
module counter_4bit #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] ccounter,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   // True when the next step in direction dir would wrap around.
   function automatic logic at_terminal(input logic [WIDTH-1:0] value,
                                        input logic             dir);
      return dir ? (value == ALL_ONES) : (value == ZERO);
   endfunction

   assign tc = at_terminal(ccounter, up);

   // Load beats counting; wrap only flags a real counting step across the boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ccounter <= RST_VAL;
         wrap     <= 1'b0;
      end else if (load) begin
         ccounter <= load_val;
         wrap     <= 1'b0;
      end else if (en) begin
         ccounter <= up ? (ccounter + ONE) : (ccounter - ONE);
         wrap     <= at_terminal(ccounter, up);
      end else begin
         wrap     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_4bit.sv
// Bench for counter_4bit: a 4-bit and a 6-bit/RST_VAL=3 instance checked
// each cycle against an arithmetic model, plus literal scenario checks.
module tb_counter_4bit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en, up, load;
   logic [3:0] load_val;
   logic [3:0] ccounter;
   logic       tc, wrap;

   logic       en6, up6, load6;
   logic [5:0] load_val6;
   logic [5:0] ccounter6;
   logic       tc6, wrap6;

   int  checks = 0;
   int  errors = 0;
   bit  check_en = 1'b0;

   int  model_count, model_wrap, nxt4;
   int  model6_count, model6_wrap, nxt6;

   always #5 clk = ~clk;

   counter_4bit dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .ccounter(ccounter), .tc(tc), .wrap(wrap)
   );

   counter_4bit #(.WIDTH(6), .RST_VAL(6'd3)) dut6 (
      .clk(clk), .rst(rst), .en(en6), .up(up6), .load(load6),
      .load_val(load_val6), .ccounter(ccounter6), .tc(tc6), .wrap(wrap6)
   );

   // Reference: plain modular arithmetic; a wrap is a step leaving 0..MOD-1.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_count <= 0;
         model_wrap  <= 0;
      end else if (load) begin
         model_count <= int'(load_val);
         model_wrap  <= 0;
      end else if (en) begin
         nxt4 = up ? model_count + 1 : model_count - 1;
         model_count <= (nxt4 + 16) % 16;
         model_wrap  <= (nxt4 < 0 || nxt4 > 15) ? 1 : 0;
      end else begin
         model_wrap  <= 0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model6_count <= 3;
         model6_wrap  <= 0;
      end else if (load6) begin
         model6_count <= int'(load_val6);
         model6_wrap  <= 0;
      end else if (en6) begin
         nxt6 = up6 ? model6_count + 1 : model6_count - 1;
         model6_count <= (nxt6 + 64) % 64;
         model6_wrap  <= (nxt6 < 0 || nxt6 > 63) ? 1 : 0;
      end else begin
         model6_wrap  <= 0;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive the 4-bit instance's inputs just after a falling edge.
   task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [3:0] lv);
      @(negedge clk);
      #1;
      en = e; up = u; load = l; load_val = lv;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("model_count4", int'(ccounter), model_count);
         checkOutput("model_wrap4", int'(wrap), model_wrap);
         checkOutput("model_tc4", int'(tc),
                     ((up && model_count == 15) || (!up && model_count == 0)) ? 1 : 0);
         checkOutput("model_count6", int'(ccounter6), model6_count);
         checkOutput("model_wrap6", int'(wrap6), model6_wrap);
         checkOutput("model_tc6", int'(tc6),
                     ((up6 && model6_count == 63) || (!up6 && model6_count == 0)) ? 1 : 0);
      end
   end

   initial begin
      en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
      en6 = 1'b1; up6 = 1'b1; load6 = 1'b0; load_val6 = 6'd0;
      #1 rst = 1'b1;
      check_en = 1'b1;

      // Reset hold for 100 ns with counting requested.
      repeat (10) begin
         @(negedge clk);
         checkOutput("reset_hold4", int'(ccounter), 0);
         checkOutput("reset_hold6", int'(ccounter6), 3);
      end
      checkOutput("reset_wrap4", int'(wrap), 0);

      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk); checkOutput("release_1", int'(ccounter), 1);
      checkOutput("release6_4", int'(ccounter6), 4);
      @(negedge clk); checkOutput("release_2", int'(ccounter), 2);
      @(negedge clk); checkOutput("release_3", int'(ccounter), 3);
      @(negedge clk);
      @(negedge clk); checkOutput("count_to_5", int'(ccounter), 5);

      // Asynchronous reset pulse between edges.
      #1 rst = 1'b1;
      #1 checkOutput("async_reset", int'(ccounter), 0);
      checkOutput("async_reset6", int'(ccounter6), 3);
      #2 rst = 1'b0;
      @(negedge clk); checkOutput("restart_1", int'(ccounter), 1);

      // Up wrap: 1 -> 15 -> 0.
      repeat (14) @(negedge clk);
      checkOutput("up_at_15", int'(ccounter), 15);
      checkOutput("up_tc_15", int'(tc), 1);
      checkOutput("up_wrap_pre", int'(wrap), 0);
      @(negedge clk);
      checkOutput("up_wrap_0", int'(ccounter), 0);
      checkOutput("up_wrap_pulse", int'(wrap), 1);
      @(negedge clk);
      checkOutput("up_wrap_clear", int'(wrap), 0);

      // Down wrap: load 1 then count down 1, 0, 15, 14.
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("down_1", int'(ccounter), 1);
      @(negedge clk);
      checkOutput("down_0", int'(ccounter), 0);
      checkOutput("down_tc_0", int'(tc), 1);
      @(negedge clk);
      checkOutput("down_15", int'(ccounter), 15);
      checkOutput("down_wrap", int'(wrap), 1);
      @(negedge clk);
      checkOutput("down_14", int'(ccounter), 14);
      checkOutput("down_wrap_clear", int'(wrap), 0);

      // Hold at 7 with enable low.
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd7);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("hold_7", int'(ccounter), 7);
         checkOutput("hold_wrap", int'(wrap), 0);
      end

      // Load wins over enable.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd9);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput("load_9", int'(ccounter), 9);

      // Load 0 while counting up from 15 must not pulse wrap.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd15);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
      checkOutput("load_15", int'(ccounter), 15);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      checkOutput("load_0_count", int'(ccounter), 0);
      checkOutput("load_0_wrap", int'(wrap), 0);

      // Wide instance: 62 -> 63 -> 0 with a wrap pulse.
      @(negedge clk); #1 load6 = 1'b1; load_val6 = 6'd62; en6 = 1'b1; up6 = 1'b1;
      @(negedge clk); #1 load6 = 1'b0;
      checkOutput("w6_load_62", int'(ccounter6), 62);
      @(negedge clk);
      checkOutput("w6_63", int'(ccounter6), 63);
      checkOutput("w6_tc", int'(tc6), 1);
      @(negedge clk);
      checkOutput("w6_wrap_0", int'(ccounter6), 0);
      checkOutput("w6_wrap_pulse", int'(wrap6), 1);

      // Randomized phase; the per-cycle compare does the checking.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         en        = ($urandom_range(0, 3) != 0);
         up        = $urandom_range(0, 1) == 1;
         load      = ($urandom_range(0, 9) == 0);
         load_val  = 4'($urandom);
         en6       = ($urandom_range(0, 3) != 0);
         up6       = $urandom_range(0, 1) == 1;
         load6     = ($urandom_range(0, 9) == 0);
         load_val6 = 6'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end

      @(negedge clk);
      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
